cmd_frame_sender: RTL and testbench

CMD_FRAME_SENDER -- requirements
Module: cmd_frame_sender

---
 rtl/cmd_frame_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 76 +++++++
 rtl/cmd_frame_sender.sv | 186 ++++++++++++++++++
 tb/tb_cmd_frame_sender.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_frame_pkg.sv
// Shared definitions for the command frame sender: FSM encoding, frame header
// byte and the frame length helper.
package cmd_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQUEST,
    WAIT_ACK,
    SEND,
    WAIT_READY,
    DONE
  } state_e;

  localparam logic [7:0] FRAME_HDR = 8'hA5;

  // Header + sequence number + payload + checksum.
  function automatic int frame_len(input int payload_bytes);
    return payload_bytes + 3;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and a registered read port
// (data appears the cycle after a pop and holds until the next pop).
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic             full_q;
  logic             empty_q;
  logic             push;
  logic             pop;

  // Flags are registered, so a pop in a full cycle cannot admit a same-cycle push.
  assign push = wr_en_i && !full_q;
  assign pop  = rd_en_i && !empty_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      rd_data_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + 1'b1;
        rd_data_q <= mem_q[rd_ptr_q];
      end
      count_q <= count_d;
      full_q  <= (count_d == FULL_CNT);
      empty_q <= (count_d == '0);
    end
  end

  assign rd_data_o = rd_data_q;
  assign full_o    = full_q;
  assign empty_o   = empty_q;

endmodule

// File: rtl/cmd_frame_sender.sv
// Queues commands and sends each as a checksummed frame through a UDP stack
// using a request/ack handshake, with an ack timeout that drops the command.
module cmd_frame_sender
  import cmd_frame_pkg::*;
#(
  parameter int CMD_W         = 2,
  parameter int PAYLOAD_BYTES = 2,
  parameter int FIFO_DEPTH    = 8,
  parameter int TIMEOUT_CYC   = 50000
) (
  input  logic             clk_50,
  input  logic             sys_rst,
  input  logic [CMD_W-1:0] cmd_in,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             udp_tx_ready,
  input  logic             app_tx_ack,
  output logic             app_tx_data_request,
  output logic             app_tx_data_valid,
  output logic [7:0]       app_tx_data,
  output logic [15:0]      udp_data_length,
  output logic             tx_done,
  output logic             tx_err,
  output logic             busy,
  output logic [7:0]       seq_num
);

  localparam int FRAME_LEN = frame_len(PAYLOAD_BYTES);
  localparam int PAY_W     = 8 * PAYLOAD_BYTES;
  localparam int IDX_W     = $clog2(FRAME_LEN + 1);
  localparam int TMR_W     = $clog2(TIMEOUT_CYC + 1);

  state_e           state_q;
  logic [7:0]       seq_q;
  logic             req_q;
  logic             vld_q;
  logic [7:0]       data_q;
  logic             done_q;
  logic             err_q;
  logic             busy_q;
  logic [TMR_W-1:0] timer_q;
  logic [IDX_W-1:0] idx_q;

  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic [CMD_W-1:0] frame_cmd;

  // The FIFO read register doubles as the frame register: it is loaded on the
  // IDLE->REQUEST pop and stays put until the next frame starts.
  assign fifo_pop = (state_q == IDLE) && !fifo_empty;

  sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_50),
    .srst_i    (sys_rst),
    .wr_en_i   (cmd_valid),
    .wr_data_i (cmd_in),
    .rd_en_i   (fifo_pop),
    .rd_data_o (frame_cmd),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  logic [PAY_W-1:0] payload;
  logic [7:0]       body_b [FRAME_LEN-1];
  logic [7:0]       chk;
  logic [7:0]       cur_byte;

  assign payload   = PAY_W'(frame_cmd);
  assign body_b[0] = FRAME_HDR;
  assign body_b[1] = seq_q;

  generate
    for (genvar gi = 0; gi < PAYLOAD_BYTES; gi++) begin : g_payload
      assign body_b[2 + gi] = payload[8 * (PAYLOAD_BYTES - 1 - gi) +: 8];
    end
  endgenerate

  always_comb begin
    chk = '0;
    for (int i = 0; i < FRAME_LEN - 1; i++) begin
      chk = chk ^ body_b[i];
    end
  end

  // Byte selected by idx_q; the last index falls through to the checksum.
  always_comb begin
    cur_byte = chk;
    for (int i = 0; i < FRAME_LEN - 1; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_byte = body_b[i];
      end
    end
  end

  always_ff @(posedge clk_50) begin
    if (sys_rst) begin
      state_q <= IDLE;
      seq_q   <= '0;
      req_q   <= 1'b0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      timer_q <= '0;
      idx_q   <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            state_q <= REQUEST;
            busy_q  <= 1'b1;
          end
        end
        REQUEST: begin
          if (udp_tx_ready) begin
            state_q <= WAIT_ACK;
            req_q   <= 1'b1;
            timer_q <= '0;
            idx_q   <= '0;
          end
        end
        WAIT_ACK: begin
          // An ack in the final timeout cycle takes priority over the drop.
          if (app_tx_ack) begin
            state_q <= SEND;
            req_q   <= 1'b0;
            vld_q   <= 1'b1;
            data_q  <= cur_byte;
            idx_q   <= IDX_W'(1);
            timer_q <= '0;
          end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        SEND: begin
          if (idx_q == IDX_W'(FRAME_LEN)) begin
            state_q <= WAIT_READY;
            vld_q   <= 1'b0;
            data_q  <= '0;
          end else begin
            data_q <= cur_byte;
            idx_q  <= idx_q + 1'b1;
          end
        end
        WAIT_READY: begin
          if (udp_tx_ready) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          seq_q   <= seq_q + 1'b1;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready           = !fifo_full && !sys_rst;
  assign app_tx_data_request = req_q;
  assign app_tx_data_valid   = vld_q;
  assign app_tx_data         = data_q;
  assign udp_data_length     = 16'(FRAME_LEN);
  assign tx_done             = done_q;
  assign tx_err              = err_q;
  assign busy                = busy_q;
  assign seq_num             = seq_q;

endmodule

// File: tb/tb_cmd_frame_sender.sv
// Scoreboard bench: instance A uses default parameters, instance B a short
// ack timeout; expected frame bytes are queued per command and popped per byte.
`timescale 1ns/1ps
module tb_cmd_frame_sender;

  logic clk_50;
  logic sys_rst;

  logic [1:0]  a_cmd, b_cmd;
  logic        a_cvalid, b_cvalid, a_cready, b_cready;
  logic        a_udp_rdy, b_udp_rdy, a_ack, b_ack;
  logic        a_req, b_req, a_vld, b_vld;
  logic [7:0]  a_data, b_data;
  logic [15:0] a_len, b_len;
  logic        a_done, b_done, a_err, b_err, a_busy, b_busy;
  logic [7:0]  a_seq, b_seq;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] a_exp[$];
  logic [7:0] b_exp[$];
  logic [7:0] a_want, b_want;
  int a_run = 0, b_run = 0;
  int a_done_cnt = 0, b_done_cnt = 0, a_err_cnt = 0, b_err_cnt = 0;

  cmd_frame_sender dut_a (
    .clk_50(clk_50), .sys_rst(sys_rst), .cmd_in(a_cmd), .cmd_valid(a_cvalid),
    .cmd_ready(a_cready), .udp_tx_ready(a_udp_rdy), .app_tx_ack(a_ack),
    .app_tx_data_request(a_req), .app_tx_data_valid(a_vld), .app_tx_data(a_data),
    .udp_data_length(a_len), .tx_done(a_done), .tx_err(a_err), .busy(a_busy),
    .seq_num(a_seq)
  );

  cmd_frame_sender #(.TIMEOUT_CYC(10)) dut_b (
    .clk_50(clk_50), .sys_rst(sys_rst), .cmd_in(b_cmd), .cmd_valid(b_cvalid),
    .cmd_ready(b_cready), .udp_tx_ready(b_udp_rdy), .app_tx_ack(b_ack),
    .app_tx_data_request(b_req), .app_tx_data_valid(b_vld), .app_tx_data(b_data),
    .udp_data_length(b_len), .tx_done(b_done), .tx_err(b_err), .busy(b_busy),
    .seq_num(b_seq)
  );

  initial clk_50 = 1'b0;
  always #10 clk_50 = ~clk_50;

  // Byte and frame-length monitors for both instances.
  always @(negedge clk_50) begin
    if (sys_rst) begin
      a_run = 0;
    end else if (a_vld === 1'b1) begin
      a_run++;
      tests_run++;
      if (a_exp.size() == 0) begin
        tests_failed++;
        $display("FAIL a_byte: got %02h, expected no byte", a_data);
      end else begin
        a_want = a_exp.pop_front();
        if (a_data !== a_want) begin
          tests_failed++;
          $display("FAIL a_byte: got %02h, expected %02h", a_data, a_want);
        end
      end
    end else if (a_run != 0) begin
      tests_run++;
      if (a_run != 5) begin
        tests_failed++;
        $display("FAIL a_frame_len: got %0d bytes, expected 5", a_run);
      end
      a_run = 0;
    end
    if (!sys_rst && a_done === 1'b1) begin
      a_done_cnt++;
      $display("[TB] A frame done, seq_num=%0d", a_seq);
    end
    if (!sys_rst && a_err === 1'b1) a_err_cnt++;
  end

  always @(negedge clk_50) begin
    if (sys_rst) begin
      b_run = 0;
    end else if (b_vld === 1'b1) begin
      b_run++;
      tests_run++;
      if (b_exp.size() == 0) begin
        tests_failed++;
        $display("FAIL b_byte: got %02h, expected no byte", b_data);
      end else begin
        b_want = b_exp.pop_front();
        if (b_data !== b_want) begin
          tests_failed++;
          $display("FAIL b_byte: got %02h, expected %02h", b_data, b_want);
        end
      end
    end else if (b_run != 0) begin
      tests_run++;
      if (b_run != 5) begin
        tests_failed++;
        $display("FAIL b_frame_len: got %0d bytes, expected 5", b_run);
      end
      b_run = 0;
    end
    if (!sys_rst && b_done === 1'b1) begin
      b_done_cnt++;
      $display("[TB] B frame done, seq_num=%0d", b_seq);
    end
    if (!sys_rst && b_err === 1'b1) begin
      b_err_cnt++;
      $display("[TB] B ack timeout, command dropped");
    end
  end

  // Expected frame for a 2-bit command with 2 payload bytes.
  task automatic exp_frame(input bit inst_b, input logic [1:0] cmd, input logic [7:0] seq);
    logic [7:0] f [5];
    f[0] = 8'hA5;
    f[1] = seq;
    f[2] = 8'h00;
    f[3] = {6'b0, cmd};
    f[4] = f[0] ^ f[1] ^ f[2] ^ f[3];
    for (int i = 0; i < 5; i++) begin
      if (inst_b) b_exp.push_back(f[i]);
      else a_exp.push_back(f[i]);
    end
  endtask

  task automatic a_push(input logic [1:0] c);
    a_cmd = c; a_cvalid = 1'b1;
    @(negedge clk_50);
    a_cvalid = 1'b0;
  endtask

  task automatic b_push(input logic [1:0] c);
    b_cmd = c; b_cvalid = 1'b1;
    @(negedge clk_50);
    b_cvalid = 1'b0;
  endtask

  task automatic wait_req(input bit inst_b);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk_50);
      seen = inst_b ? (b_req === 1'b1) : (a_req === 1'b1);
    end
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL wait_req_%s: got no request in 200 cycles, expected one", inst_b ? "b" : "a");
    end
  endtask

  task automatic wait_done(input bit inst_b, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk_50);
      seen = inst_b ? (b_done === 1'b1) : (a_done === 1'b1);
    end
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL wait_done_%s: got no tx_done in %0d cycles, expected one", inst_b ? "b" : "a", budget);
    end
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    a_cvalid = 1'b0; b_cvalid = 1'b0; a_ack = 1'b0; b_ack = 1'b0;
    a_udp_rdy = 1'b0; b_udp_rdy = 1'b0; a_cmd = '0; b_cmd = '0;
    repeat (2) @(negedge clk_50);
    sys_rst = 1'b0;
    a_exp.delete(); b_exp.delete();
    a_done_cnt = 0; b_done_cnt = 0; a_err_cnt = 0; b_err_cnt = 0;
    @(negedge clk_50);
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    a_cvalid = 1'b1; a_cmd = 2'b11; a_ack = 1'b1; a_udp_rdy = 1'b1;
    b_cvalid = 1'b0; b_cmd = '0; b_ack = 1'b0; b_udp_rdy = 1'b0;
    repeat (3) @(negedge clk_50);
    tests_run++; if (a_cready !== 1'b0) begin tests_failed++; $display("FAIL rst_cmd_ready: got %b, expected 0", a_cready); end
    tests_run++; if (a_req !== 1'b0) begin tests_failed++; $display("FAIL rst_request: got %b, expected 0", a_req); end
    tests_run++; if (a_vld !== 1'b0) begin tests_failed++; $display("FAIL rst_valid: got %b, expected 0", a_vld); end
    tests_run++; if (a_data !== 8'h00) begin tests_failed++; $display("FAIL rst_data: got %02h, expected 00", a_data); end
    tests_run++; if ({a_done, a_err, a_busy} !== 3'b000) begin tests_failed++; $display("FAIL rst_done_err_busy: got %b, expected 000", {a_done, a_err, a_busy}); end
    tests_run++; if (a_seq !== 8'd0) begin tests_failed++; $display("FAIL rst_seq: got %0d, expected 0", a_seq); end
    tests_run++; if (a_len !== 16'd5 || b_len !== 16'd5) begin tests_failed++; $display("FAIL rst_length: got %0d/%0d, expected 5", a_len, b_len); end
    tests_run++; if (b_cready !== 1'b0) begin tests_failed++; $display("FAIL rst_b_cmd_ready: got %b, expected 0", b_cready); end
    a_cvalid = 1'b0;
    sys_rst = 1'b0;
    repeat (2) @(negedge clk_50);
    tests_run++; if (a_cready !== 1'b1 || a_busy !== 1'b0) begin tests_failed++; $display("FAIL post_rst_idle: got ready=%b busy=%b, expected ready=1 busy=0", a_cready, a_busy); end
    a_ack = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    a_udp_rdy = 1'b1;
    a_exp.push_back(8'hA5); a_exp.push_back(8'h00); a_exp.push_back(8'h00);
    a_exp.push_back(8'h02); a_exp.push_back(8'hA7);
    a_push(2'b10);
    wait_req(1'b0);
    repeat (2) @(negedge clk_50);
    a_ack = 1'b1;
    @(negedge clk_50);
    a_ack = 1'b0;
    tests_run++; if (a_vld !== 1'b1 || a_req !== 1'b0) begin tests_failed++; $display("FAIL first_byte_timing: got valid=%b req=%b, expected valid=1 req=0", a_vld, a_req); end
    wait_done(1'b0, 50);
    repeat (2) @(negedge clk_50);
    tests_run++; if (a_seq !== 8'd1) begin tests_failed++; $display("FAIL single_seq: got %0d, expected 1", a_seq); end
    tests_run++; if (a_done_cnt != 1) begin tests_failed++; $display("FAIL single_done_count: got %0d, expected 1", a_done_cnt); end
    tests_run++; if (a_exp.size() != 0) begin tests_failed++; $display("FAIL single_bytes_left: got %0d, expected 0", a_exp.size()); end
  endtask

  task automatic test_full();
    do_reset();
    a_udp_rdy = 1'b1;
    exp_frame(1'b0, 2'd3, 8'd0);
    a_push(2'd3);
    wait_req(1'b0);
    // One command sits in the frame register; eight more fill the queue.
    for (int i = 0; i < 8; i++) begin
      tests_run++; if (a_cready !== 1'b1) begin tests_failed++; $display("FAIL fill_ready_%0d: got %b, expected 1", i, a_cready); end
      exp_frame(1'b0, 2'(i), 8'(i + 1));
      a_push(2'(i));
    end
    tests_run++; if (a_cready !== 1'b0) begin tests_failed++; $display("FAIL full_ready: got %b, expected 0", a_cready); end
    a_push(2'd1);
    tests_run++; if (a_cready !== 1'b0 || a_req !== 1'b1) begin tests_failed++; $display("FAIL full_hold: got ready=%b req=%b, expected ready=0 req=1", a_cready, a_req); end
    a_ack = 1'b1;
    wait_done(1'b0, 50);
    @(negedge clk_50);
    tests_run++; if (a_busy !== 1'b0) begin tests_failed++; $display("FAIL b2b_idle: got busy=%b, expected 0", a_busy); end
    @(negedge clk_50);
    tests_run++; if (a_busy !== 1'b1 || a_req !== 1'b0) begin tests_failed++; $display("FAIL b2b_request: got busy=%b req=%b, expected busy=1 req=0", a_busy, a_req); end
    @(negedge clk_50);
    tests_run++; if (a_req !== 1'b1) begin tests_failed++; $display("FAIL b2b_wait_ack: got req=%b, expected 1", a_req); end
    for (int i = 0; i < 600 && a_done_cnt < 9; i++) @(negedge clk_50);
    a_ack = 1'b0;
    repeat (4) @(negedge clk_50);
    tests_run++; if (a_done_cnt != 9) begin tests_failed++; $display("FAIL full_frames: got %0d, expected 9", a_done_cnt); end
    tests_run++; if (a_seq !== 8'd9 || a_exp.size() != 0) begin tests_failed++; $display("FAIL full_seq: got seq=%0d left=%0d, expected seq=9 left=0", a_seq, a_exp.size()); end
  endtask

  task automatic test_timeout();
    int cnt;
    do_reset();
    b_udp_rdy = 1'b1;
    b_push(2'd1);
    b_push(2'd2);
    exp_frame(1'b1, 2'd2, 8'd0);
    wait_req(1'b1);
    cnt = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_50);
      if (b_req !== 1'b1) break;
      cnt++;
    end
    tests_run++; if (cnt != 10) begin tests_failed++; $display("FAIL timeout_req_cycles: got %0d, expected 10", cnt); end
    wait_req(1'b1);
    tests_run++; if (b_err_cnt != 1 || b_seq !== 8'd0) begin tests_failed++; $display("FAIL timeout_err: got err=%0d seq=%0d, expected err=1 seq=0", b_err_cnt, b_seq); end
    b_ack = 1'b1;
    @(negedge clk_50);
    b_ack = 1'b0;
    wait_done(1'b1, 50);
    repeat (2) @(negedge clk_50);
    tests_run++; if (b_seq !== 8'd1 || b_exp.size() != 0) begin tests_failed++; $display("FAIL timeout_next: got seq=%0d left=%0d, expected seq=1 left=0", b_seq, b_exp.size()); end
  endtask

  task automatic test_ack_at_timeout();
    b_push(2'd3);
    exp_frame(1'b1, 2'd3, 8'd1);
    wait_req(1'b1);
    repeat (9) @(negedge clk_50);
    tests_run++; if (b_req !== 1'b1) begin tests_failed++; $display("FAIL edge_req_cycle10: got %b, expected 1", b_req); end
    b_ack = 1'b1;
    @(negedge clk_50);
    b_ack = 1'b0;
    tests_run++; if (b_vld !== 1'b1) begin tests_failed++; $display("FAIL edge_ack_wins: got valid=%b, expected 1", b_vld); end
    wait_done(1'b1, 50);
    repeat (2) @(negedge clk_50);
    tests_run++; if (b_err_cnt != 1 || b_seq !== 8'd2) begin tests_failed++; $display("FAIL edge_result: got err=%0d seq=%0d, expected err=1 seq=2", b_err_cnt, b_seq); end
  endtask

  task automatic test_reset_midframe();
    int nbytes;
    do_reset();
    a_udp_rdy = 1'b1;
    a_ack = 1'b1;
    exp_frame(1'b0, 2'd2, 8'd0);
    a_push(2'd2);
    a_push(2'd1);
    nbytes = 0;
    for (int i = 0; i < 100 && nbytes < 3; i++) begin
      @(negedge clk_50);
      if (a_vld === 1'b1) nbytes++;
    end
    tests_run++; if (nbytes != 3) begin tests_failed++; $display("FAIL midframe_reach: got %0d bytes, expected 3", nbytes); end
    sys_rst = 1'b1;
    @(negedge clk_50);
    tests_run++; if (a_vld !== 1'b0 || a_req !== 1'b0 || a_busy !== 1'b0) begin tests_failed++; $display("FAIL midframe_rst: got valid=%b req=%b busy=%b, expected 000", a_vld, a_req, a_busy); end
    tests_run++; if (a_seq !== 8'd0 || a_data !== 8'h00) begin tests_failed++; $display("FAIL midframe_rst_seq: got seq=%0d data=%02h, expected 0/00", a_seq, a_data); end
    a_exp.delete();
    sys_rst = 1'b0;
    repeat (6) @(negedge clk_50);
    tests_run++; if (a_busy !== 1'b0 || a_cready !== 1'b1) begin tests_failed++; $display("FAIL midframe_queue_empty: got busy=%b ready=%b, expected busy=0 ready=1", a_busy, a_cready); end
    exp_frame(1'b0, 2'd3, 8'd0);
    a_push(2'd3);
    wait_done(1'b0, 50);
    repeat (2) @(negedge clk_50);
    tests_run++; if (a_seq !== 8'd1 || a_exp.size() != 0) begin tests_failed++; $display("FAIL midframe_fresh: got seq=%0d left=%0d, expected seq=1 left=0", a_seq, a_exp.size()); end
    a_ack = 1'b0;
  endtask

  task automatic test_wrap();
    int sent;
    logic [1:0] c;
    do_reset();
    a_udp_rdy = 1'b1;
    a_ack = 1'b1;
    sent = 0;
    for (int i = 0; i < 20000 && sent < 257; i++) begin
      if (a_cready === 1'b1) begin
        c = 2'($urandom_range(0, 3));
        a_cmd = c;
        a_cvalid = 1'b1;
        exp_frame(1'b0, c, 8'(sent));
        sent++;
      end else begin
        a_cvalid = 1'b0;
      end
      @(negedge clk_50);
    end
    a_cvalid = 1'b0;
    for (int i = 0; i < 10000 && a_done_cnt < 257; i++) @(negedge clk_50);
    repeat (3) @(negedge clk_50);
    tests_run++; if (a_done_cnt != 257) begin tests_failed++; $display("FAIL wrap_frames: got %0d, expected 257", a_done_cnt); end
    tests_run++; if (a_seq !== 8'd1) begin tests_failed++; $display("FAIL wrap_seq: got %0d, expected 1", a_seq); end
    tests_run++; if (a_exp.size() != 0 || a_err_cnt != 0) begin tests_failed++; $display("FAIL wrap_tail: got left=%0d err=%0d, expected 0/0", a_exp.size(), a_err_cnt); end
    a_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_timeout();
    test_ack_at_timeout();
    test_reset_midframe();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
